// File: rtl/slow_fpu_scheduler.sv
// Slow FPU scheduler: captures one multi-cycle FP op from EX, hands it to the
// slow unit over valid/ready, and holds the result until the shared FP
// write port is free. It stalls ID on structural, RAW, WAW and
// write-port-starvation hazards.
// Optional build macro SLOW_FPU_PERF_EN adds the perf_busy / perf_stall counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing in flight, waiting for ex_slow_valid
// REQ   | op captured, presenting request until fpu_req_ready
// BUSY  | request accepted, waiting for fpu_resp_valid
// WB    | result held, writing back when the pipeline leaves the port free
module slow_fpu_scheduler #(
    parameter int DATA_W     = 32,
    parameter int OP_W       = 3,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_slow_disp,
    input  logic [2:0]        id_rs_fp_use,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rs3,
    input  logic              id_fp_wr,
    input  logic [4:0]        id_rd,
    input  logic              ex_slow_valid,
    input  logic [OP_W-1:0]   ex_op,
    input  logic [4:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_a,
    input  logic [DATA_W-1:0] ex_b,
    output logic              fpu_req_valid,
    input  logic              fpu_req_ready,
    output logic [OP_W-1:0]   fpu_req_op,
    output logic [DATA_W-1:0] fpu_req_a,
    output logic [DATA_W-1:0] fpu_req_b,
    input  logic              fpu_resp_valid,
    input  logic [DATA_W-1:0] fpu_resp_data,
    output logic              fpu_resp_ready,
    input  logic              pipe_fp_wb,
    output logic              slow_wb_en,
    output logic [4:0]        slow_wb_rd,
    output logic [DATA_W-1:0] slow_wb_data,
    output logic              stall_id
`ifdef SLOW_FPU_PERF_EN
   ,output logic [31:0]       perf_busy,
    output logic [31:0]       perf_stall
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              pend_valid;
    logic [OP_W-1:0]   pend_op;
    logic [4:0]        pend_rd;
    logic [DATA_W-1:0] pend_a;
    logic [DATA_W-1:0] pend_b;
    logic [DATA_W-1:0] result;
    logic [SW-1:0]     starve;

    logic hit_rs1;
    logic hit_rs2;
    logic hit_rs3;
    logic hit_rd;
    logic haz_single;
    logic haz_raw;
    logic haz_waw;
    logic haz_starve;

    // State register; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt      = state;
        fpu_req_valid  = 1'b0;
        fpu_resp_ready = 1'b0;
        slow_wb_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ex_slow_valid) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                fpu_req_valid = 1'b1;
                if (fpu_req_ready) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                fpu_resp_ready = 1'b1;
                if (fpu_resp_valid) begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                slow_wb_en = !pipe_fp_wb;
                if (!pipe_fp_wb) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture of the dispatched op, the unit's result and the write-port starve count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_valid <= 1'b0;
            pend_op    <= '0;
            pend_rd    <= '0;
            pend_a     <= '0;
            pend_b     <= '0;
            result     <= '0;
            starve     <= '0;
        end else begin
            if (state == S_IDLE && ex_slow_valid) begin
                pend_valid <= 1'b1;
                pend_op    <= ex_op;
                pend_rd    <= ex_rd;
                pend_a     <= ex_a;
                pend_b     <= ex_b;
            end
            if (state == S_BUSY && fpu_resp_valid) begin
                result <= fpu_resp_data;
            end
            if (state == S_WB) begin
                if (!pipe_fp_wb) begin
                    pend_valid <= 1'b0;
                    starve     <= '0;
                end else if (starve != SW'(STARVE_MAX)) begin
                    starve <= starve + SW'(1);
                end
            end
        end
    end

    assign fpu_req_op   = pend_op;
    assign fpu_req_a    = pend_a;
    assign fpu_req_b    = pend_b;
    assign slow_wb_rd   = slow_wb_en ? pend_rd : 5'd0;
    assign slow_wb_data = slow_wb_en ? result : '0;

    // The op still sitting in EX counts as pending so back-to-back users see it.
    assign hit_rs1 = (pend_valid && id_rs1 == pend_rd) || (ex_slow_valid && id_rs1 == ex_rd);
    assign hit_rs2 = (pend_valid && id_rs2 == pend_rd) || (ex_slow_valid && id_rs2 == ex_rd);
    assign hit_rs3 = (pend_valid && id_rs3 == pend_rd) || (ex_slow_valid && id_rs3 == ex_rd);
    assign hit_rd  = (pend_valid && id_rd  == pend_rd) || (ex_slow_valid && id_rd  == ex_rd);

    assign haz_single = id_slow_disp && (state != S_IDLE || ex_slow_valid);
    assign haz_raw    = (id_rs_fp_use[0] && hit_rs1) ||
                        (id_rs_fp_use[1] && hit_rs2) ||
                        (id_rs_fp_use[2] && hit_rs3);
    assign haz_waw    = id_fp_wr && hit_rd;
    assign haz_starve = (state == S_WB) && (starve == SW'(STARVE_MAX));
    assign stall_id   = haz_single || haz_raw || haz_waw || haz_starve;

`ifdef SLOW_FPU_PERF_EN
    // Free-running occupancy and stall counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (state != S_IDLE) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if (stall_id) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_slow_fpu_scheduler.sv
// Bench for slow_fpu_scheduler: a table of stall vectors, directed sequences for
// the multi-cycle corners, and random traffic against a transaction-level model.
module tb_slow_fpu_scheduler;

    localparam int DATA_W     = 32;
    localparam int OP_W       = 3;
    localparam int STARVE_MAX = 7;

    logic              clk = 1'b0;
    logic              rstn;
    logic              id_slow_disp;
    logic [2:0]        id_rs_fp_use;
    logic [4:0]        id_rs1, id_rs2, id_rs3;
    logic              id_fp_wr;
    logic [4:0]        id_rd;
    logic              ex_slow_valid;
    logic [OP_W-1:0]   ex_op;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_a, ex_b;
    logic              fpu_req_valid;
    logic              fpu_req_ready;
    logic [OP_W-1:0]   fpu_req_op;
    logic [DATA_W-1:0] fpu_req_a, fpu_req_b;
    logic              fpu_resp_valid;
    logic [DATA_W-1:0] fpu_resp_data;
    logic              fpu_resp_ready;
    logic              pipe_fp_wb;
    logic              slow_wb_en;
    logic [4:0]        slow_wb_rd;
    logic [DATA_W-1:0] slow_wb_data;
    logic              stall_id;
`ifdef SLOW_FPU_PERF_EN
    logic [31:0]       perf_busy, perf_stall;
`endif

    always #5 clk = ~clk;

    slow_fpu_scheduler #(.DATA_W(DATA_W), .OP_W(OP_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .id_slow_disp(id_slow_disp), .id_rs_fp_use(id_rs_fp_use),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .id_fp_wr(id_fp_wr), .id_rd(id_rd),
        .ex_slow_valid(ex_slow_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
        .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready), .fpu_req_op(fpu_req_op),
        .fpu_req_a(fpu_req_a), .fpu_req_b(fpu_req_b),
        .fpu_resp_valid(fpu_resp_valid), .fpu_resp_data(fpu_resp_data), .fpu_resp_ready(fpu_resp_ready),
        .pipe_fp_wb(pipe_fp_wb), .slow_wb_en(slow_wb_en), .slow_wb_rd(slow_wb_rd),
        .slow_wb_data(slow_wb_data), .stall_id(stall_id)
`ifdef SLOW_FPU_PERF_EN
       ,.perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    // Transaction-level model: one op record with progress flags.
    bit              m_pend, m_sent, m_have;
    logic [OP_W-1:0] m_op;
    logic [4:0]      m_rd;
    logic [31:0]     m_a, m_b, m_res;
    int              m_loss;
    logic [31:0]     m_busy_cnt, m_stall_cnt;

    typedef struct packed {
        logic       disp;
        logic [2:0] rs_use;
        logic [4:0] rs1, rs2, rs3;
        logic       fp_wr;
        logic [4:0] rd;
        logic       ex_v;
        logic [4:0] ex_rd;
        logic       exp_stall;
    } tv_t;

    tv_t tv [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit reg_hit(input logic [4:0] r);
        return (m_pend && r == m_rd) || (ex_slow_valid && r == ex_rd);
    endfunction

    function automatic bit model_stall();
        bit s;
        s = id_slow_disp && (m_pend || ex_slow_valid);
        s = s || (id_rs_fp_use[0] && reg_hit(id_rs1));
        s = s || (id_rs_fp_use[1] && reg_hit(id_rs2));
        s = s || (id_rs_fp_use[2] && reg_hit(id_rs3));
        s = s || (id_fp_wr && reg_hit(id_rd));
        s = s || (m_pend && m_have && m_loss >= STARVE_MAX);
        return s;
    endfunction

    task automatic clear_inputs();
        id_slow_disp = 0; id_rs_fp_use = 0; id_rs1 = 0; id_rs2 = 0; id_rs3 = 0;
        id_fp_wr = 0; id_rd = 0;
        ex_slow_valid = 0; ex_op = 0; ex_rd = 0; ex_a = 0; ex_b = 0;
        fpu_req_ready = 0; fpu_resp_valid = 0; fpu_resp_data = 0; pipe_fp_wb = 0;
    endtask

    // Let inputs settle and compare every output with the model.
    task automatic look();
        bit e_wb;
        #2;
        e_wb = m_pend && m_have && !pipe_fp_wb;
        chk("req_valid", fpu_req_valid, m_pend && !m_sent);
        if (m_pend && !m_sent) begin
            chk("req_op", fpu_req_op, m_op);
            chk("req_a", fpu_req_a, m_a);
            chk("req_b", fpu_req_b, m_b);
        end
        chk("resp_ready", fpu_resp_ready, m_pend && m_sent && !m_have);
        chk("wb_en", slow_wb_en, e_wb);
        chk("wb_rd", slow_wb_rd, e_wb ? m_rd : 5'd0);
        chk("wb_data", slow_wb_data, e_wb ? m_res : 32'd0);
        chk("stall_id", stall_id, model_stall());
`ifdef SLOW_FPU_PERF_EN
        chk("perf_busy", perf_busy, m_busy_cnt);
        chk("perf_stall", perf_stall, m_stall_cnt);
`endif
    endtask

    // Advance the model with this cycle's inputs, then cross the clock edge.
    task automatic tick();
        bit e_stall;
        e_stall = model_stall();
        if (rstn && ex_slow_valid && m_pend) begin
            n_chk++; n_bad++;
            $display("FAIL illegal_dispatch got=1 exp=0 t=%0t", $time);
        end
        if (!rstn) begin
            m_pend = 0; m_sent = 0; m_have = 0; m_loss = 0;
            m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_res = 0;
            m_busy_cnt = 0; m_stall_cnt = 0;
        end else begin
            if (m_pend) m_busy_cnt = m_busy_cnt + 1;
            if (e_stall) m_stall_cnt = m_stall_cnt + 1;
            if (!m_pend) begin
                if (ex_slow_valid) begin
                    m_pend = 1; m_sent = 0; m_have = 0; m_loss = 0;
                    m_op = ex_op; m_rd = ex_rd; m_a = ex_a; m_b = ex_b;
                end
            end else if (!m_sent) begin
                if (fpu_req_ready) m_sent = 1;
            end else if (!m_have) begin
                if (fpu_resp_valid) begin
                    m_have = 1; m_res = fpu_resp_data;
                end
            end else if (!pipe_fp_wb) begin
                m_pend = 0; m_sent = 0; m_have = 0; m_loss = 0;
            end else if (m_loss < STARVE_MAX) begin
                m_loss++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        look();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pend = 0; m_sent = 0; m_have = 0; m_loss = 0;
        m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_res = 0;
        m_busy_cnt = 0; m_stall_cnt = 0;

        tv[0]  = '{1'b0, 3'b000, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0};
        tv[1]  = '{1'b1, 3'b000, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0};
        tv[2]  = '{1'b1, 3'b000, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b1, 5'd9,  1'b1};
        tv[3]  = '{1'b0, 3'b001, 5'd5, 5'd0,  5'd0, 1'b0, 5'd0,  1'b1, 5'd5,  1'b1};
        tv[4]  = '{1'b0, 3'b010, 5'd5, 5'd6,  5'd0, 1'b0, 5'd0,  1'b1, 5'd5,  1'b0};
        tv[5]  = '{1'b0, 3'b100, 5'd1, 5'd1,  5'd0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b1};
        tv[6]  = '{1'b0, 3'b000, 5'd0, 5'd0,  5'd0, 1'b1, 5'd17, 1'b1, 5'd17, 1'b1};
        tv[7]  = '{1'b0, 3'b000, 5'd0, 5'd0,  5'd0, 1'b0, 5'd17, 1'b1, 5'd17, 1'b0};
        tv[8]  = '{1'b0, 3'b111, 5'd1, 5'd2,  5'd3, 1'b0, 5'd0,  1'b1, 5'd4,  1'b0};
        tv[9]  = '{1'b0, 3'b001, 5'd5, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd5,  1'b0};
        tv[10] = '{1'b0, 3'b010, 5'd0, 5'd31, 5'd0, 1'b0, 5'd0,  1'b1, 5'd31, 1'b1};
        tv[11] = '{1'b0, 3'b010, 5'd0, 5'd15, 5'd0, 1'b0, 5'd0,  1'b1, 5'd31, 1'b0};

        rstn = 0;
        clear_inputs();
        @(posedge clk);
        #1;

        // Stall decode in IDLE, held in reset so the EX pulses never launch an op.
        for (int i = 0; i < 12; i++) begin
            id_slow_disp = tv[i].disp; id_rs_fp_use = tv[i].rs_use;
            id_rs1 = tv[i].rs1; id_rs2 = tv[i].rs2; id_rs3 = tv[i].rs3;
            id_fp_wr = tv[i].fp_wr; id_rd = tv[i].rd;
            ex_slow_valid = tv[i].ex_v; ex_rd = tv[i].ex_rd;
            look();
            chk($sformatf("tbl_stall_%0d", i), stall_id, tv[i].exp_stall);
            tick();
        end
        clear_inputs();
        cycle();
        rstn = 1;
        look();
        chk("rst_req_valid", fpu_req_valid, 0);
        chk("rst_resp_ready", fpu_resp_ready, 0);
        chk("rst_wb_en", slow_wb_en, 0);
        chk("rst_stall", stall_id, 0);
        tick();

        // fdiv f3 = 6.0 / 2.0, unit ready at once, response 10 cycles after the request.
        fpu_req_ready = 1; ex_slow_valid = 1; ex_op = 3'd1; ex_rd = 5'd3;
        ex_a = 32'h40C0_0000; ex_b = 32'h4000_0000;
        look();
        chk("t1_no_req_yet", fpu_req_valid, 0);
        tick();
        ex_slow_valid = 0; ex_a = 32'hDEAD_BEEF; ex_b = 32'h1234_5678;
        look();
        chk("t1_req_valid", fpu_req_valid, 1);
        chk("t1_req_op", fpu_req_op, 3'd1);
        chk("t1_req_a", fpu_req_a, 32'h40C0_0000);
        chk("t1_req_b", fpu_req_b, 32'h4000_0000);
        tick();
        for (int i = 0; i < 9; i++) begin
            id_rs_fp_use = 3'b001;
            id_rs1 = (i < 5) ? 5'd3 : 5'd4;
            id_slow_disp = (i == 7);
            look();
            chk("t1_busy_resp_ready", fpu_resp_ready, 1);
            if (i < 5) chk("t2_raw_f3", stall_id, 1);
            else if (i == 7) chk("t4_disp_busy", stall_id, 1);
            else chk("t2_f4_free", stall_id, 0);
            tick();
        end
        id_slow_disp = 0; id_rs1 = 5'd3;
        fpu_resp_valid = 1; fpu_resp_data = 32'h4040_0000;
        look();
        chk("t1_no_wb_on_resp", slow_wb_en, 0);
        tick();
        fpu_resp_valid = 0;
        look();
        chk("t1_wb_en", slow_wb_en, 1);
        chk("t1_wb_rd", slow_wb_rd, 5'd3);
        chk("t1_wb_data", slow_wb_data, 32'h4040_0000);
        chk("t2_stall_on_write", stall_id, 1);
        tick();
        id_slow_disp = 1;
        look();
        chk("t2_stall_clear", stall_id, 0);
        chk("t4_disp_free", stall_id, 0);
        chk("t1_wb_done", slow_wb_en, 0);
        tick();
        clear_inputs();

        // Write port starved by the main pipeline for 10 cycles.
        fpu_req_ready = 1; ex_slow_valid = 1; ex_op = 3'd2; ex_rd = 5'd7;
        ex_a = 32'h1111_1111; ex_b = 32'h2222_2222;
        cycle();
        ex_slow_valid = 0;
        cycle();
        fpu_resp_valid = 1; fpu_resp_data = 32'hCAFE_0007;
        cycle();
        fpu_resp_valid = 0; pipe_fp_wb = 1;
        for (int k = 1; k <= 10; k++) begin
            look();
            chk("t3_starve_stall", stall_id, (k >= 8));
            chk("t3_no_wb", slow_wb_en, 0);
            tick();
        end
        pipe_fp_wb = 0;
        look();
        chk("t3_wb_en", slow_wb_en, 1);
        chk("t3_wb_rd", slow_wb_rd, 5'd7);
        chk("t3_wb_data", slow_wb_data, 32'hCAFE_0007);
        tick();
        look();
        chk("t3_stall_clear", stall_id, 0);
        tick();
        clear_inputs();

        // Request back-pressure: op and operands must hold until accepted.
        ex_slow_valid = 1; ex_op = 3'd5; ex_rd = 5'd12;
        ex_a = 32'hA5A5_0001; ex_b = 32'h5A5A_0002;
        cycle();
        ex_slow_valid = 0; ex_op = 3'd0; ex_a = 32'h0; ex_b = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            look();
            chk("t5_hold_valid", fpu_req_valid, 1);
            chk("t5_hold_op", fpu_req_op, 3'd5);
            chk("t5_hold_a", fpu_req_a, 32'hA5A5_0001);
            chk("t5_hold_b", fpu_req_b, 32'h5A5A_0002);
            tick();
        end
        fpu_req_ready = 1;
        look();
        chk("t5_handshake", fpu_req_valid, 1);
        tick();
        fpu_req_ready = 0; fpu_resp_valid = 1; fpu_resp_data = 32'h0000_0055;
        look();
        chk("t5_req_dropped", fpu_req_valid, 0);
        chk("t5_resp_ready", fpu_resp_ready, 1);
        tick();
        fpu_resp_valid = 0;
        look();
        chk("t5_wb_rd", slow_wb_rd, 5'd12);
        tick();
        clear_inputs();

        // Reset in the middle of an op.
        fpu_req_ready = 1; ex_slow_valid = 1; ex_op = 3'd3; ex_rd = 5'd20;
        ex_a = 32'h1; ex_b = 32'h2;
        cycle();
        ex_slow_valid = 0;
        cycle();
        look();
        chk("t6_busy", fpu_resp_ready, 1);
        rstn = 0;
        tick();
        rstn = 1; fpu_resp_valid = 1; fpu_resp_data = 32'h7777_7777;
        look();
        chk("t6_req_valid", fpu_req_valid, 0);
        chk("t6_resp_ready", fpu_resp_ready, 0);
        chk("t6_wb_en", slow_wb_en, 0);
        chk("t6_wb_rd", slow_wb_rd, 0);
        chk("t6_wb_data", slow_wb_data, 0);
        chk("t6_stall", stall_id, 0);
`ifdef SLOW_FPU_PERF_EN
        chk("t6_perf_busy", perf_busy, 0);
        chk("t6_perf_stall", perf_stall, 0);
`endif
        tick();
        fpu_resp_valid = 0;
        look();
        chk("t6_idle_ignores_resp", slow_wb_en, 0);
        tick();
        clear_inputs();

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rstn = ($urandom_range(0, 299) != 0);
            ex_slow_valid = !m_pend && ($urandom_range(0, 3) == 0);
            ex_op = OP_W'($urandom);
            ex_rd = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ex_a = $urandom; ex_b = $urandom;
            id_slow_disp = 1'($urandom_range(0, 1));
            id_rs_fp_use = 3'($urandom);
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_rs3 = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            id_fp_wr = 1'($urandom_range(0, 1));
            id_rd = 5'($urandom_range(0, 7));
            fpu_req_ready = ($urandom_range(0, 2) != 0);
            fpu_resp_valid = (m_pend && !m_sent) ? 1'b0 : ($urandom_range(0, 3) == 0);
            fpu_resp_data = $urandom;
            pipe_fp_wb = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
